// File: rtl/jelly2_img_line_moment_weighted_if.sv
// Interfaces for the weighted line-moment stage.
//
// jelly2_img_line_moment_weighted_img_if : pixel stream with line/frame framing
//    row_first/row_last : first/last line of frame
//    col_first/col_last : first/last pixel of line
//    de                 : pixel lies in the active area
//    data               : pixel value
//    valid              : pixel strobe
//
// jelly2_img_line_moment_weighted_if : per-line moment result, valid/ready
//    first/last         : result belongs to the first/last line of the frame
//    m0/m1/m2           : sum w, sum w*x, sum w*x*x
//    sat                : an accumulator saturated on this line
//    valid/ready        : handshake (ready driven by the consumer)

interface jelly2_img_line_moment_weighted_img_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  row_first;
   logic                  row_last;
   logic                  col_first;
   logic                  col_last;
   logic                  de;
   logic [DATA_WIDTH-1:0] data;
   logic                  valid;

   modport master (output row_first, row_last, col_first, col_last, de, data, valid);
   modport slave  (input  row_first, row_last, col_first, col_last, de, data, valid);
endinterface

interface jelly2_img_line_moment_weighted_if #(
   parameter int M0_WIDTH = 20,
   parameter int M1_WIDTH = 32,
   parameter int M2_WIDTH = 44
);
   logic                first;
   logic                last;
   logic [M0_WIDTH-1:0] m0;
   logic [M1_WIDTH-1:0] m1;
   logic [M2_WIDTH-1:0] m2;
   logic                sat;
   logic                valid;
   logic                ready;

   modport master (output first, last, m0, m1, m2, sat, valid, input  ready);
   modport slave  (input  first, last, m0, m1, m2, sat, valid, output ready);
endinterface

// File: rtl/jelly2_img_line_moment_weighted.sv
// Per-line weighted image moments M0 = sum(w), M1 = sum(w*x), M2 = sum(w*x*x).
// The weight comes from the pixel value (raw, binary threshold or weighted
// threshold). Completed line results are queued in a first-word-fall-through
// FIFO so the consumer can stall without stalling the image stream.
//
// Ports:
//    clk, reset_n        : clock, asynchronous active-low reset
//    cke                 : clock enable of the input/accumulate pipeline and FIFO push
//    s_img               : pixel stream (slave)
//    param_mode          : 0 raw, 1 binary threshold, 2 weighted threshold, 3 as 0
//    param_threshold     : unsigned threshold, sampled on the col_first pixel
//    clear_overflow      : clears m_overflow
//    m_moment            : line results (master, valid/ready)
//    m_overflow          : sticky, a line result was dropped on a full FIFO

module jelly2_img_line_moment_weighted #(
   parameter int DATA_WIDTH     = 8,
   parameter int X_WIDTH        = 12,
   parameter int M0_WIDTH       = 20,
   parameter int M1_WIDTH       = 32,
   parameter int M2_WIDTH       = 44,
   parameter int USE_M2         = 1,
   parameter int FIFO_PTR_WIDTH = 2
) (
   input  logic                                        clk,
   input  logic                                        reset_n,
   input  logic                                        cke,
   jelly2_img_line_moment_weighted_img_if.slave        s_img,
   input  logic [1:0]                                  param_mode,
   input  logic [DATA_WIDTH-1:0]                       param_threshold,
   input  logic                                        clear_overflow,
   jelly2_img_line_moment_weighted_if.master           m_moment,
   output logic                                        m_overflow
);

   localparam int DEPTH = 1 << FIFO_PTR_WIDTH;
   localparam int WX_W  = DATA_WIDTH + X_WIDTH;
   localparam int WXX_W = DATA_WIDTH + 2 * X_WIDTH;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // wide enough that accumulator + term never wraps before the clamp
   localparam int SAT_W = max_int(max_int(max_int(M0_WIDTH, DATA_WIDTH), max_int(M1_WIDTH, WX_W)),
                                  max_int(M2_WIDTH, WXX_W)) + 1;

   localparam logic [SAT_W-1:0] LIM0 = SAT_W'({M0_WIDTH{1'b1}});
   localparam logic [SAT_W-1:0] LIM1 = SAT_W'({M1_WIDTH{1'b1}});
   localparam logic [SAT_W-1:0] LIM2 = SAT_W'({M2_WIDTH{1'b1}});

   function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                                input logic [SAT_W-1:0] t,
                                                input logic [SAT_W-1:0] lim);
      logic [SAT_W-1:0] s;
      s = a + t;
      return (s > lim) ? lim : s;
   endfunction

   function automatic logic sat_hit(input logic [SAT_W-1:0] a,
                                    input logic [SAT_W-1:0] t,
                                    input logic [SAT_W-1:0] lim);
      logic [SAT_W-1:0] s;
      s = a + t;
      return s > lim;
   endfunction

   typedef struct packed {
      logic                first;
      logic                last;
      logic [M0_WIDTH-1:0] m0;
      logic [M1_WIDTH-1:0] m1;
      logic [M2_WIDTH-1:0] m2;
      logic                sat;
   } result_t;

   // ---------------- stage 0: weight, column index, products ----------------
   logic                  accept;
   logic [1:0]            mode_line;
   logic [DATA_WIDTH-1:0] th_line;
   logic [X_WIDTH-1:0]    x_cnt;
   logic [1:0]            mode_cur;
   logic [DATA_WIDTH-1:0] th_cur;
   logic [DATA_WIDTH-1:0] w_cur;
   logic [X_WIDTH-1:0]    x_cur;
   logic [WX_W-1:0]       wx_cur;
   logic [WXX_W-1:0]      wxx_cur;

   logic                  vld_p0;
   logic                  col_first_p0;
   logic                  col_last_p0;
   logic                  row_first_p0;
   logic                  row_last_p0;
   logic [DATA_WIDTH-1:0] w_p0;
   logic [WX_W-1:0]       wx_p0;
   logic [WXX_W-1:0]      wxx_p0;

   assign accept = cke & s_img.valid;

   // The col_first pixel uses the live parameters; the rest of the line uses the held copy.
   always_comb begin
      mode_cur = s_img.col_first ? param_mode : mode_line;
      th_cur   = s_img.col_first ? param_threshold : th_line;
      x_cur    = s_img.col_first ? '0 : x_cnt;
      case (mode_cur)
         2'd1:    w_cur = (s_img.data >= th_cur) ? DATA_WIDTH'(1) : '0;
         2'd2:    w_cur = (s_img.data >= th_cur) ? s_img.data : '0;
         default: w_cur = s_img.data;
      endcase
      if (!s_img.de) w_cur = '0;
      wx_cur  = WX_W'(w_cur) * WX_W'(x_cur);
      wxx_cur = (USE_M2 != 0) ? WXX_W'(wx_cur) * WXX_W'(x_cur) : '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_p0       <= 1'b0;
         col_first_p0 <= 1'b0;
         col_last_p0  <= 1'b0;
         row_first_p0 <= 1'b0;
         row_last_p0  <= 1'b0;
         mode_line    <= '0;
         th_line      <= '0;
         x_cnt        <= '0;
      end else if (cke) begin
         vld_p0 <= s_img.valid;
         if (s_img.valid) begin
            col_first_p0 <= s_img.col_first;
            col_last_p0  <= s_img.col_last;
            row_first_p0 <= s_img.row_first;
            row_last_p0  <= s_img.row_last;
            // x advances only past de pixels and wraps silently
            x_cnt        <= x_cur + X_WIDTH'(s_img.de);
            if (s_img.col_first) begin
               mode_line <= param_mode;
               th_line   <= param_threshold;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         w_p0   <= w_cur;
         wx_p0  <= wx_cur;
         wxx_p0 <= wxx_cur;
      end
   end

   // ---------------- stage 1: saturating accumulation ----------------
   logic                vld_p1;
   logic                col_last_p1;
   logic                row_first_p1;
   logic                row_last_p1;
   logic                sat_p1;
   logic [M0_WIDTH-1:0] acc0_p1;
   logic [M1_WIDTH-1:0] acc1_p1;
   logic [M2_WIDTH-1:0] acc2_p1;
   logic [SAT_W-1:0]    base0, base1, base2;
   logic [SAT_W-1:0]    term0, term1, term2;
   logic                hit_any;

   // col_first loads the pixel's own terms instead of adding to the previous line
   always_comb begin
      base0   = col_first_p0 ? '0 : SAT_W'(acc0_p1);
      base1   = col_first_p0 ? '0 : SAT_W'(acc1_p1);
      base2   = (col_first_p0 || USE_M2 == 0) ? '0 : SAT_W'(acc2_p1);
      term0   = SAT_W'(w_p0);
      term1   = SAT_W'(wx_p0);
      term2   = (USE_M2 != 0) ? SAT_W'(wxx_p0) : '0;
      hit_any = sat_hit(base0, term0, LIM0) | sat_hit(base1, term1, LIM1)
              | sat_hit(base2, term2, LIM2);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_p1       <= 1'b0;
         col_last_p1  <= 1'b0;
         row_first_p1 <= 1'b0;
         row_last_p1  <= 1'b0;
         sat_p1       <= 1'b0;
      end else if (cke) begin
         vld_p1 <= vld_p0;
         if (vld_p0) begin
            col_last_p1  <= col_last_p0;
            row_first_p1 <= row_first_p0;
            row_last_p1  <= row_last_p0;
            sat_p1       <= (col_first_p0 ? 1'b0 : sat_p1) | hit_any;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (cke && vld_p0) begin
         acc0_p1 <= M0_WIDTH'(sat_add(base0, term0, LIM0));
         acc1_p1 <= M1_WIDTH'(sat_add(base1, term1, LIM1));
         acc2_p1 <= M2_WIDTH'(sat_add(base2, term2, LIM2));
      end
   end

   // ---------------- stage 2: result capture for the FIFO push ----------------
   logic    push_p2;
   result_t res_p2;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         push_p2 <= 1'b0;
      end else if (cke) begin
         push_p2 <= vld_p1 & col_last_p1;
      end
   end

   always_ff @(posedge clk) begin
      if (cke && vld_p1 && col_last_p1) begin
         res_p2.first <= row_first_p1;
         res_p2.last  <= row_last_p1;
         res_p2.m0    <= acc0_p1;
         res_p2.m1    <= acc1_p1;
         res_p2.m2    <= (USE_M2 != 0) ? acc2_p1 : '0;
         res_p2.sat   <= sat_p1;
      end
   end

   // ---------------- output FIFO (first-word fall-through) ----------------
   logic [FIFO_PTR_WIDTH:0] wr_ptr, rd_ptr;
   result_t                 mem [DEPTH];
   result_t                 head;
   logic                    empty, full, push, pop, wr_en, drop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[FIFO_PTR_WIDTH] != rd_ptr[FIFO_PTR_WIDTH])
               && (wr_ptr[FIFO_PTR_WIDTH-1:0] == rd_ptr[FIFO_PTR_WIDTH-1:0]);
   assign push  = cke & push_p2;
   assign pop   = ~empty & m_moment.ready;
   // a full FIFO still accepts when the head leaves on the same edge
   assign wr_en = push & (~full | pop);
   assign drop  = push & full & ~pop;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         m_overflow <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         // a drop in the same cycle as the clear keeps the flag set
         if (drop)                m_overflow <= 1'b1;
         else if (clear_overflow) m_overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[FIFO_PTR_WIDTH-1:0]] <= res_p2;
   end

   assign head           = mem[rd_ptr[FIFO_PTR_WIDTH-1:0]];
   assign m_moment.valid = ~empty;
   assign m_moment.first = ~empty & head.first;
   assign m_moment.last  = ~empty & head.last;
   assign m_moment.sat   = ~empty & head.sat;
   assign m_moment.m0    = empty ? '0 : head.m0;
   assign m_moment.m1    = empty ? '0 : head.m1;
   assign m_moment.m2    = (empty || USE_M2 == 0) ? '0 : head.m2;

endmodule

// File: tb/tb_jelly2_img_line_moment_weighted.sv
// Self-checking bench for jelly2_img_line_moment_weighted.
// A main instance (default widths) is checked through a scoreboard of
// per-line expected results; a second instance with a 4-bit M0 shares the
// pixel stream and is used for the saturation scenario.

module tb_jelly2_img_line_moment_weighted;

   localparam int DW = 8, XW = 12, M0W = 20, M1W = 32, M2W = 44, PW = 2, M0W_S = 4;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       cke = 1'b1;
   logic [1:0] param_mode = 2'd0;
   logic [7:0] param_threshold = 8'd0;
   logic       clear_overflow = 1'b0;
   logic       ovf, ovf_s;

   always #5 clk = ~clk;

   jelly2_img_line_moment_weighted_img_if #(.DATA_WIDTH(DW)) si ();
   jelly2_img_line_moment_weighted_if #(.M0_WIDTH(M0W),   .M1_WIDTH(M1W), .M2_WIDTH(M2W)) mo ();
   jelly2_img_line_moment_weighted_if #(.M0_WIDTH(M0W_S), .M1_WIDTH(M1W), .M2_WIDTH(M2W)) mo_s ();

   jelly2_img_line_moment_weighted #(
      .DATA_WIDTH(DW), .X_WIDTH(XW), .M0_WIDTH(M0W), .M1_WIDTH(M1W), .M2_WIDTH(M2W),
      .USE_M2(1), .FIFO_PTR_WIDTH(PW)
   ) dut (
      .clk(clk), .reset_n(reset_n), .cke(cke), .s_img(si),
      .param_mode(param_mode), .param_threshold(param_threshold),
      .clear_overflow(clear_overflow), .m_moment(mo), .m_overflow(ovf)
   );

   jelly2_img_line_moment_weighted #(
      .DATA_WIDTH(DW), .X_WIDTH(XW), .M0_WIDTH(M0W_S), .M1_WIDTH(M1W), .M2_WIDTH(M2W),
      .USE_M2(1), .FIFO_PTR_WIDTH(PW)
   ) dut_s (
      .clk(clk), .reset_n(reset_n), .cke(cke), .s_img(si),
      .param_mode(param_mode), .param_threshold(param_threshold),
      .clear_overflow(clear_overflow), .m_moment(mo_s), .m_overflow(ovf_s)
   );

   typedef struct {
      logic        first;
      logic        last;
      logic        sat;
      logic [63:0] m0;
      logic [63:0] m1;
      logic [63:0] m2;
   } exp_t;

   exp_t       sb[$];
   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] pix_data [64];
   logic       pix_de   [64];

   // scoreboard: every accepted result of the main instance is compared here
   always @(negedge clk) begin
      if (reset_n && mo.valid && mo.ready) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_result: got m0=%0d m1=%0d, required no result", mo.m0, mo.m1);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (mo.first !== e.first || mo.last !== e.last || mo.sat !== e.sat ||
                mo.m0 !== M0W'(e.m0) || mo.m1 !== M1W'(e.m1) || mo.m2 !== M2W'(e.m2)) begin
               n_err++;
               $display("FAIL line_result: got f=%0b l=%0b s=%0b m0=%0d m1=%0d m2=%0d, required f=%0b l=%0b s=%0b m0=%0d m1=%0d m2=%0d",
                        mo.first, mo.last, mo.sat, mo.m0, mo.m1, mo.m2,
                        e.first, e.last, e.sat, e.m0, e.m1, e.m2);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // drives one line from pix_data/pix_de and records its expected result
   task automatic drive_line(input int n, input logic rf, input logic rl,
                             input logic [1:0] mode, input logic [7:0] th,
                             input logic has_last, input logic keep, input int stall_at);
      exp_t        e;
      logic [63:0] w, x;
      logic [63:0] lim0, lim1, lim2;
      e.m0 = 0; e.m1 = 0; e.m2 = 0; x = 0;
      for (int i = 0; i < n; i++) begin
         if (i == stall_at) begin
            cke = 1'b0;
            si.valid = 1'b1; si.col_first = 1'b1; si.col_last = 1'b1;
            si.de = 1'b1; si.data = 8'hFF;
            repeat (5) tick();
            cke = 1'b1;
         end
         si.valid     = 1'b1;
         si.col_first = (i == 0);
         si.col_last  = (i == n - 1) && has_last;
         si.row_first = rf;
         si.row_last  = rl;
         si.de        = pix_de[i];
         si.data      = pix_data[i];
         if (i == 0) begin
            param_mode = mode; param_threshold = th;
         end else begin
            param_mode = mode + 2'd1; param_threshold = th ^ 8'h5A;
         end
         case (mode)
            2'd1:    w = (pix_data[i] >= th) ? 64'd1 : 64'd0;
            2'd2:    w = (pix_data[i] >= th) ? 64'(pix_data[i]) : 64'd0;
            default: w = 64'(pix_data[i]);
         endcase
         if (!pix_de[i]) w = 0;
         e.m0 += w;
         e.m1 += w * x;
         e.m2 += w * x * x;
         if (pix_de[i]) x = (x + 1) % 4096;
         tick();
      end
      si.valid = 1'b0; si.col_first = 1'b0; si.col_last = 1'b0;
      lim0 = (64'd1 << M0W) - 1; lim1 = (64'd1 << M1W) - 1; lim2 = (64'd1 << M2W) - 1;
      e.sat = 1'b0;
      if (e.m0 > lim0) begin e.m0 = lim0; e.sat = 1'b1; end
      if (e.m1 > lim1) begin e.m1 = lim1; e.sat = 1'b1; end
      if (e.m2 > lim2) begin e.m2 = lim2; e.sat = 1'b1; end
      e.first = rf;
      e.last  = rl;
      if (has_last && keep) sb.push_back(e);
   endtask

   task automatic wait_drain();
      int k = 0;
      while (sb.size() != 0 && k < 200) begin tick(); k++; end
      repeat (2) tick();
   endtask

   task automatic test_reset();
      repeat (3) tick();
      n_cmp++; if (mo.valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b, required 0", mo.valid); end
      n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %0b, required 0", ovf); end
      n_cmp++; if (mo.m0 !== '0 || mo.m2 !== '0) begin n_err++; $display("FAIL reset_data: got m0=%0d m2=%0d, required 0", mo.m0, mo.m2); end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_raw();
      int lat = 0;
      pix_data[0] = 0; pix_data[1] = 2; pix_data[2] = 0; pix_data[3] = 3;
      for (int i = 0; i < 4; i++) pix_de[i] = 1'b1;
      drive_line(4, 1'b1, 1'b0, 2'd0, 8'd0, 1'b1, 1'b1, -1);
      while (!mo.valid && lat < 10) begin tick(); lat++; end
      n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL raw_latency: got %0d edges, required 3", lat); end
      n_cmp++; if (mo.m0 !== 20'd5 || mo.m1 !== 32'd11 || mo.m2 !== 44'd29) begin
         n_err++; $display("FAIL raw_sums: got %0d/%0d/%0d, required 5/11/29", mo.m0, mo.m1, mo.m2); end
      n_cmp++; if (mo.first !== 1'b1 || mo.last !== 1'b0) begin
         n_err++; $display("FAIL raw_flags: got first=%0b last=%0b, required 1/0", mo.first, mo.last); end
      wait_drain();
   endtask

   task automatic test_threshold();
      int k;
      pix_data[0] = 5; pix_data[1] = 10; pix_data[2] = 200; pix_data[3] = 9;
      for (int m = 1; m <= 2; m++) begin
         drive_line(4, 1'b0, 1'b0, 2'(m), 8'd10, 1'b1, 1'b1, -1);
         k = 0; while (!mo.valid && k < 10) begin tick(); k++; end
         n_cmp++;
         if (m == 1 && (mo.m0 !== 20'd2 || mo.m1 !== 32'd3 || mo.m2 !== 44'd5)) begin
            n_err++; $display("FAIL mode1_sums: got %0d/%0d/%0d, required 2/3/5", mo.m0, mo.m1, mo.m2); end
         if (m == 2 && (mo.m0 !== 20'd210 || mo.m1 !== 32'd410 || mo.m2 !== 44'd810)) begin
            n_err++; $display("FAIL mode2_sums: got %0d/%0d/%0d, required 210/410/810", mo.m0, mo.m1, mo.m2); end
         wait_drain();
      end
   endtask

   task automatic test_de_gaps_cke();
      int k;
      for (int i = 0; i < 3; i++) pix_data[i] = 1;
      pix_de[0] = 1'b1; pix_de[1] = 1'b0; pix_de[2] = 1'b1;
      for (int s = 0; s < 2; s++) begin
         drive_line(3, 1'b0, 1'b1, 2'd0, 8'd0, 1'b1, 1'b1, (s == 0) ? -1 : 1);
         k = 0; while (!mo.valid && k < 10) begin tick(); k++; end
         n_cmp++;
         if (mo.m0 !== 20'd2 || mo.m1 !== 32'd1 || mo.m2 !== 44'd1 || mo.last !== 1'b1) begin
            n_err++; $display("FAIL de_gap_stall%0d: got %0d/%0d/%0d last=%0b, required 2/1/1 last=1",
                              s, mo.m0, mo.m1, mo.m2, mo.last); end
         wait_drain();
      end
   endtask

   task automatic test_saturation();
      int k;
      for (int i = 0; i < 20; i++) begin pix_data[i] = 1; pix_de[i] = 1'b1; end
      drive_line(20, 1'b0, 1'b0, 2'd0, 8'd0, 1'b1, 1'b1, -1);
      k = 0; while (!mo_s.valid && k < 10) begin tick(); k++; end
      n_cmp++; if (mo_s.m0 !== 4'd15 || mo_s.sat !== 1'b1) begin
         n_err++; $display("FAIL sat_line: got m0=%0d sat=%0b, required 15/1", mo_s.m0, mo_s.sat); end
      wait_drain();
      drive_line(2, 1'b0, 1'b0, 2'd0, 8'd0, 1'b1, 1'b1, -1);
      k = 0; while (!mo_s.valid && k < 10) begin tick(); k++; end
      n_cmp++; if (mo_s.m0 !== 4'd2 || mo_s.sat !== 1'b0) begin
         n_err++; $display("FAIL sat_cleared: got m0=%0d sat=%0b, required 2/0", mo_s.m0, mo_s.sat); end
      wait_drain();
   endtask

   task automatic test_overflow();
      mo.ready = 1'b0;
      for (int l = 0; l < 6; l++) begin
         for (int i = 0; i < 3; i++) begin pix_data[i] = 8'(l * 10 + i + 1); pix_de[i] = 1'b1; end
         drive_line(3, 1'b0, 1'b0, 2'd0, 8'd0, 1'b1, (l < 4), -1);
      end
      repeat (5) tick();
      n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL overflow_set: got %0b, required 1", ovf); end
      n_cmp++; if (mo.valid !== 1'b1 || mo.m0 !== M0W'(sb[0].m0)) begin
         n_err++; $display("FAIL stall_head: got valid=%0b m0=%0d, required 1/%0d", mo.valid, mo.m0, sb[0].m0); end
      repeat (3) tick();
      n_cmp++; if (mo.m0 !== M0W'(sb[0].m0) || mo.m1 !== M1W'(sb[0].m1)) begin
         n_err++; $display("FAIL stall_hold: got m0=%0d m1=%0d, required %0d/%0d", mo.m0, mo.m1, sb[0].m0, sb[0].m1); end
      mo.ready = 1'b1;
      wait_drain();
      n_cmp++; if (sb.size() != 0 || mo.valid !== 1'b0) begin
         n_err++; $display("FAIL overflow_drain: got %0d pending valid=%0b, required 0/0", sb.size(), mo.valid); end
      n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL overflow_sticky: got %0b, required 1", ovf); end
      clear_overflow = 1'b1; tick(); clear_overflow = 1'b0;
      n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL overflow_clear: got %0b, required 0", ovf); end
   endtask

   task automatic test_restart();
      for (int i = 0; i < 3; i++) begin pix_data[i] = 8'd50; pix_de[i] = 1'b1; end
      drive_line(3, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, -1);
      pix_data[0] = 1; pix_data[1] = 2; pix_data[2] = 3;
      drive_line(3, 1'b1, 1'b1, 2'd0, 8'd0, 1'b1, 1'b1, -1);
      wait_drain();
      n_cmp++; if (sb.size() != 0 || mo.valid !== 1'b0) begin
         n_err++; $display("FAIL restart: got %0d pending valid=%0b, required 0/0", sb.size(), mo.valid); end
   endtask

   task automatic test_reset_midline();
      mo.ready = 1'b0;
      for (int i = 0; i < 4; i++) begin pix_data[i] = 8'(i + 7); pix_de[i] = 1'b1; end
      drive_line(4, 1'b0, 1'b0, 2'd0, 8'd0, 1'b1, 1'b1, -1);
      drive_line(4, 1'b0, 1'b0, 2'd0, 8'd0, 1'b1, 1'b1, -1);
      repeat (5) tick();
      drive_line(2, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, -1);
      reset_n = 1'b0;
      #1;
      n_cmp++; if (mo.valid !== 1'b0 || mo.m0 !== '0) begin
         n_err++; $display("FAIL reset_midline: got valid=%0b m0=%0d, required 0/0", mo.valid, mo.m0); end
      sb.delete();
      repeat (2) tick();
      reset_n = 1'b1;
      mo.ready = 1'b1;
      tick();
      pix_data[0] = 4; pix_data[1] = 0; pix_data[2] = 6;
      drive_line(3, 1'b1, 1'b0, 2'd0, 8'd0, 1'b1, 1'b1, -1);
      wait_drain();
      n_cmp++; if (sb.size() != 0 || mo.valid !== 1'b0) begin
         n_err++; $display("FAIL after_reset_line: got %0d pending valid=%0b, required 0/0", sb.size(), mo.valid); end
   endtask

   task automatic test_back_to_back();
      for (int l = 0; l < 10; l++) begin
         int n;
         n = (l == 0) ? 1 : $urandom_range(1, 12);
         for (int i = 0; i < n; i++) begin
            pix_data[i] = 8'($urandom);
            pix_de[i]   = ($urandom_range(0, 3) != 0);
         end
         drive_line(n, (l == 0), (l == 9), 2'($urandom), 8'($urandom), 1'b1, 1'b1, -1);
      end
      wait_drain();
      n_cmp++; if (sb.size() != 0) begin
         n_err++; $display("FAIL back_to_back_drain: got %0d pending, required 0", sb.size()); end
   endtask

   initial begin
      si.valid = 1'b0; si.col_first = 1'b0; si.col_last = 1'b0;
      si.row_first = 1'b0; si.row_last = 1'b0; si.de = 1'b0; si.data = '0;
      mo.ready = 1'b1;
      mo_s.ready = 1'b1;
      test_reset();
      test_raw();
      test_threshold();
      test_de_gaps_cke();
      test_saturation();
      test_overflow();
      test_restart();
      test_reset_midline();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/jelly2_img_line_moment_weighted.md
Name: jelly2_img_line_moment_weighted

Overview:
Computes per-line weighted image moments M0 = Σw, M1 = Σw·x and M2 = Σw·x² from a multi-bit pixel stream. The pixel weight w comes from the pixel value, optionally after thresholding. Sits after the image pipeline's line/frame framing, in the same position as the binary line-moment stage, and feeds centroid and variance estimation. Results go out through a FIFO with valid/ready handshake, so downstream may stall without stalling the image stream.

Parameters:
DATA_WIDTH, 8, pixel value width.
X_WIDTH, 12, column index width; max line length 2^X_WIDTH de pixels.
M0_WIDTH, 20, M0 accumulator width.
M1_WIDTH, 32, M1 accumulator width.
M2_WIDTH, 44, M2 accumulator width.
USE_M2, 1, 0 = M2 logic removed; m_moment_m2 tied to 0.
FIFO_PTR_WIDTH, 2, output FIFO depth = 2^FIFO_PTR_WIDTH entries.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous reset, active low
cke  in  1  clock enable for the input/accumulate pipeline only
s_img_row_first  in  1  first line of frame
s_img_row_last  in  1  last line of frame
s_img_col_first  in  1  first pixel of line
s_img_col_last  in  1  last pixel of line
s_img_de  in  1  pixel is in the active area
s_img_data  in  DATA_WIDTH  pixel value
s_img_valid  in  1  pixel strobe
param_mode  in  2  0 raw, 1 binary threshold, 2 weighted threshold, 3 reserved (treated as 0)
param_threshold  in  DATA_WIDTH  threshold, unsigned compare
clear_overflow  in  1  clears m_overflow
m_moment_first  out  1  result belongs to first line
m_moment_last  out  1  result belongs to last line
m_moment_m0  out  M0_WIDTH  Σw
m_moment_m1  out  M1_WIDTH  Σw·x
m_moment_m2  out  M2_WIDTH  Σw·x²
m_moment_sat  out  1  an accumulator saturated on this line
m_moment_valid  out  1  result valid
m_moment_ready  in  1  downstream accepts
m_overflow  out  1  sticky: a line result was dropped

Behaviour:
- Reset (async assert, sync release): pipeline valids = 0, FIFO empty, m_moment_valid = 0, m_overflow = 0. Data outputs are 0.
- Pixel accepted when cke & s_img_valid. cke low freezes stages 0–1 and the FIFO push; it does not freeze the FIFO pop or output side.
- param_mode and param_threshold are sampled on the accepted col_first pixel and held for the whole line.
- Weight, using the mode held for the line (or param_* directly on the col_first pixel):
  - mode 0: w = data.
  - mode 1: w = (data ≥ th) ? 1 : 0.
  - mode 2: w = (data ≥ th) ? data : 0.
  - de = 0 gives w = 0.
- x = index of the pixel among de pixels in the line. The first de pixel has x = 0. x resets on col_first and increments only after a de pixel. x wraps modulo 2^X_WIDTH; no flag is raised.
- Stage 0 registers w, x, w·x and w·x·x (products at full width) plus the flags.
- Stage 1 accumulates. col_first loads the pixel's own terms instead of adding. Each accumulator saturates at all-ones. Any saturation on the line sets the line's sat flag; col_first clears it.
- On the accepted col_last pixel, the completed {first, last, m0, m1, m2, sat} is pushed the cycle after stage 1 updates.
- Latency with cke = 1, FIFO empty and ready = 1: m_moment_valid rises 3 clk edges after the edge that accepts col_last.
- A line with col_first and col_last on the same pixel produces a valid 1-pixel result.
- FIFO is first-word-fall-through. Pop when valid & ready. Outputs are held stable while valid & !ready.
- Push while full and no simultaneous pop: the result is dropped and m_overflow is set. Push while full with a simultaneous pop succeeds.
- clear_overflow clears m_overflow. If a drop occurs in the same cycle as clear_overflow, the set wins.
- col_first mid-line (missing col_last) restarts accumulation with no push.
- reset_n asserted mid-line discards partial sums and all FIFO contents.

Test Plan:
- Raw mode, 1 line, de = 1, data = {0,2,0,3}, ready = 1 -> m0 = 5, m1 = 2·1+3·3 = 11, m2 = 2·1+3·9 = 29, first/last per row flags, valid 3 edges after col_last.
- Mode 1, th = 10, data = {5,10,200,9} -> m0 = 2, m1 = 3, m2 = 5. Mode 2, same data -> m0 = 210, m1 = 410, m2 = 810.
- de gaps: de = {1,0,1}, data = 1, mode 0 -> x sequence 0,–,1 gives m0 = 2, m1 = 1, m2 = 1. Toggle cke low for 5 cycles mid-line -> identical result.
- M0_WIDTH = 4, 20 pixels of data = 1 -> m0 = 15, sat = 1. Next line of 2 pixels -> sat = 0, m0 = 2.
- ready = 0 for 6 lines with FIFO depth 4 -> 4 results retained in order, m_overflow = 1. Release ready -> the 4 oldest lines pop in order. clear_overflow -> m_overflow = 0.
- Assert reset_n low mid-line with 2 results queued -> m_moment_valid = 0 immediately. Next full line -> correct fresh sums.
